// File: rtl/voice_allocator_pkg.sv
// Shared types and default sizes for the polyphonic voice allocator.
package voice_allocator_pkg;
   localparam int VOICE_COUNT_DEF = 8;
   localparam int AGE_WIDTH_DEF   = 8;

   typedef enum logic [1:0] {
      FREE      = 2'd0,
      HELD      = 2'd1,
      RELEASING = 2'd2
   } voice_state_t;

   typedef enum logic {
      IDLE   = 1'b0,
      DECIDE = 1'b1
   } alloc_state_t;
endpackage

// File: rtl/voice_picker.sv
// Combinational voice choice: retrigger, free, oldest releasing,
// then oldest held; plus the note-off release mask.
module voice_picker
   import voice_allocator_pkg::*;
#(
   parameter int VOICE_COUNT    = VOICE_COUNT_DEF,
   parameter int NOTE_WIDTH     = 7,
   parameter int VELOCITY_WIDTH = 7,
   parameter int AGE_WIDTH      = AGE_WIDTH_DEF,
   localparam int IDX_W         = $clog2(VOICE_COUNT)
) (
   input  voice_state_t              state_i [VOICE_COUNT],
   input  logic [NOTE_WIDTH-1:0]     note_i  [VOICE_COUNT],
   input  logic [AGE_WIDTH-1:0]      age_i   [VOICE_COUNT],
   input  logic                      ev_is_on_i,
   input  logic [NOTE_WIDTH-1:0]     ev_note_i,
   input  logic [VELOCITY_WIDTH-1:0] ev_velocity_i,
   output logic [IDX_W-1:0]          target_o,
   output logic                      target_valid_o,
   output logic [VOICE_COUNT-1:0]    release_mask_o
);
   logic                 note_on_eff;
   logic                 retrig_hit, free_hit, rel_hit, held_hit;
   logic [IDX_W-1:0]     retrig_idx, free_idx, rel_idx, held_idx;
   logic [AGE_WIDTH-1:0] rel_age, held_age;

   // Scanning downward with >= keeps the lowest index on every tie.
   always_comb begin
      note_on_eff    = ev_is_on_i && (ev_velocity_i != '0);
      retrig_hit     = 1'b0;
      free_hit       = 1'b0;
      rel_hit        = 1'b0;
      held_hit       = 1'b0;
      retrig_idx     = '0;
      free_idx       = '0;
      rel_idx        = '0;
      held_idx       = '0;
      rel_age        = '0;
      held_age       = '0;
      release_mask_o = '0;
      for (int i = VOICE_COUNT - 1; i >= 0; i--) begin
         if (state_i[i] == HELD && note_i[i] == ev_note_i) begin
            retrig_hit        = 1'b1;
            retrig_idx        = IDX_W'(i);
            release_mask_o[i] = !note_on_eff;
         end
         if (state_i[i] == FREE) begin
            free_hit = 1'b1;
            free_idx = IDX_W'(i);
         end
         if (state_i[i] == RELEASING && (!rel_hit || age_i[i] >= rel_age)) begin
            rel_hit = 1'b1;
            rel_idx = IDX_W'(i);
            rel_age = age_i[i];
         end
         if (state_i[i] == HELD && (!held_hit || age_i[i] >= held_age)) begin
            held_hit = 1'b1;
            held_idx = IDX_W'(i);
            held_age = age_i[i];
         end
      end
   end

   always_comb begin
      target_valid_o = note_on_eff;
      if (retrig_hit)    target_o = retrig_idx;
      else if (free_hit) target_o = free_idx;
      else if (rel_hit)  target_o = rel_idx;
      else               target_o = held_idx;
   end
endmodule

// File: rtl/voice_allocator.sv
// Polyphony front end: maps note events to voice slots and emits
// per-voice start/release pulses.
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int VOICE_COUNT    = VOICE_COUNT_DEF,
   parameter int NOTE_WIDTH     = 7,
   parameter int VELOCITY_WIDTH = 7,
   parameter int AGE_WIDTH      = AGE_WIDTH_DEF
) (
   input  logic                                  clock_50_000_000,
   input  logic                                  reset_l,
   input  logic                                  event_valid,
   output logic                                  event_ready,
   input  logic                                  event_is_on,
   input  logic [NOTE_WIDTH-1:0]                 event_note,
   input  logic [VELOCITY_WIDTH-1:0]             event_velocity,
   input  logic [VOICE_COUNT-1:0]                envelope_end,
   output logic [VOICE_COUNT-1:0]                voice_note_on,
   output logic [VOICE_COUNT-1:0]                voice_note_off,
   output logic [VOICE_COUNT*NOTE_WIDTH-1:0]     voice_note,
   output logic [VOICE_COUNT*VELOCITY_WIDTH-1:0] voice_velocity,
   output logic [VOICE_COUNT-1:0]                voice_active
);
   localparam int IDX_W = $clog2(VOICE_COUNT);
   localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

   alloc_state_t              state_q, state_d;
   logic                      ev_on_q, ev_on_d;
   logic [NOTE_WIDTH-1:0]     ev_note_q, ev_note_d;
   logic [VELOCITY_WIDTH-1:0] ev_vel_q, ev_vel_d;
   voice_state_t              vstate_q [VOICE_COUNT];
   voice_state_t              vstate_d [VOICE_COUNT];
   logic [NOTE_WIDTH-1:0]     vnote_q  [VOICE_COUNT];
   logic [NOTE_WIDTH-1:0]     vnote_d  [VOICE_COUNT];
   logic [VELOCITY_WIDTH-1:0] vvel_q   [VOICE_COUNT];
   logic [VELOCITY_WIDTH-1:0] vvel_d   [VOICE_COUNT];
   logic [AGE_WIDTH-1:0]      vage_q   [VOICE_COUNT];
   logic [AGE_WIDTH-1:0]      vage_d   [VOICE_COUNT];
   logic [VOICE_COUNT-1:0]    on_q, on_d, off_q, off_d;
   logic [IDX_W-1:0]          target;
   logic                      target_valid;
   logic [VOICE_COUNT-1:0]    release_mask;

   voice_picker #(
      .VOICE_COUNT    (VOICE_COUNT),
      .NOTE_WIDTH     (NOTE_WIDTH),
      .VELOCITY_WIDTH (VELOCITY_WIDTH),
      .AGE_WIDTH      (AGE_WIDTH)
   ) u_picker (
      .state_i        (vstate_q),
      .note_i         (vnote_q),
      .age_i          (vage_q),
      .ev_is_on_i     (ev_on_q),
      .ev_note_i      (ev_note_q),
      .ev_velocity_i  (ev_vel_q),
      .target_o       (target),
      .target_valid_o (target_valid),
      .release_mask_o (release_mask)
   );

   assign event_ready = reset_l && (state_q == IDLE);

   always_comb begin
      state_d   = state_q;
      ev_on_d   = ev_on_q;
      ev_note_d = ev_note_q;
      ev_vel_d  = ev_vel_q;
      vstate_d  = vstate_q;
      vnote_d   = vnote_q;
      vvel_d    = vvel_q;
      vage_d    = vage_q;
      on_d      = '0;
      off_d     = '0;
      for (int i = 0; i < VOICE_COUNT; i++) begin
         if (vstate_q[i] == RELEASING && envelope_end[i]) begin
            vstate_d[i] = FREE;
            vage_d[i]   = '0;
         end
      end
      unique case (state_q)
         IDLE: begin
            if (event_valid) begin
               state_d   = DECIDE;
               ev_on_d   = event_is_on;
               ev_note_d = event_note;
               ev_vel_d  = event_velocity;
            end
         end
         DECIDE: begin
            state_d = IDLE;
            off_d   = release_mask;
            for (int i = 0; i < VOICE_COUNT; i++) begin
               // The chosen voice overrides a coincident envelope_end.
               if (target_valid && target == IDX_W'(i)) begin
                  vstate_d[i] = HELD;
                  vnote_d[i]  = ev_note_q;
                  vvel_d[i]   = ev_vel_q;
                  vage_d[i]   = '0;
                  on_d[i]     = 1'b1;
               end else begin
                  if (release_mask[i]) vstate_d[i] = RELEASING;
                  if (vstate_d[i] != FREE && vage_q[i] != AGE_MAX)
                     vage_d[i] = vage_q[i] + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
         state_q   <= IDLE;
         ev_on_q   <= 1'b0;
         ev_note_q <= '0;
         ev_vel_q  <= '0;
         on_q      <= '0;
         off_q     <= '0;
         for (int i = 0; i < VOICE_COUNT; i++) begin
            vstate_q[i] <= FREE;
            vnote_q[i]  <= '0;
            vvel_q[i]   <= '0;
            vage_q[i]   <= '0;
         end
      end else begin
         state_q   <= state_d;
         ev_on_q   <= ev_on_d;
         ev_note_q <= ev_note_d;
         ev_vel_q  <= ev_vel_d;
         on_q      <= on_d;
         off_q     <= off_d;
         vstate_q  <= vstate_d;
         vnote_q   <= vnote_d;
         vvel_q    <= vvel_d;
         vage_q    <= vage_d;
      end
   end

   assign voice_note_on  = on_q;
   assign voice_note_off = off_q;

   always_comb begin
      voice_note     = '0;
      voice_velocity = '0;
      voice_active   = '0;
      for (int i = 0; i < VOICE_COUNT; i++) begin
         voice_note[i*NOTE_WIDTH +: NOTE_WIDTH]             = vnote_q[i];
         voice_velocity[i*VELOCITY_WIDTH +: VELOCITY_WIDTH] = vvel_q[i];
         voice_active[i] = (vstate_q[i] != FREE);
      end
   end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony front end: accepts decoded MIDI note events and maps each to one of VOICE_COUNT voice slots.
- Emits per-voice single-cycle note_on/note_off pulses that drive one Envelope (and oscillator) instance per voice.
- Consumes each voice's envelope_end pulse to return that voice to the free pool.
- Sits between the MIDI decoder and the per-voice Envelope/oscillator array.

Parameters:
VOICE_COUNT, 8, number of voice slots (power of two, 2..16)
NOTE_WIDTH, 7, MIDI note number width
VELOCITY_WIDTH, 7, MIDI velocity width
AGE_WIDTH, 8, saturating per-voice age counter width

Ports:
clock_50_000_000  in   1  system clock
reset_l  in   1  reset
event_valid  in   1  note event offered
event_ready  out  1  allocator can accept an event
event_is_on  in   1  1 = note-on, 0 = note-off
event_note  in   NOTE_WIDTH  MIDI note number
event_velocity  in   VELOCITY_WIDTH  MIDI velocity
envelope_end  in   VOICE_COUNT  per-voice pulse: release phase finished
voice_note_on  out  VOICE_COUNT  per-voice 1-cycle start pulse
voice_note_off  out  VOICE_COUNT  per-voice 1-cycle release pulse
voice_note  out  VOICE_COUNT*NOTE_WIDTH  packed note per voice, voice 0 in LSBs
voice_velocity  out  VOICE_COUNT*VELOCITY_WIDTH  packed velocity per voice
voice_active  out  VOICE_COUNT  1 = voice not FREE

Behaviour:
Reset:
- Reset reset_l, asynchronous, active-low; clock clock_50_000_000.
- During reset: all voices FREE, ages 0, all outputs 0, event_ready 0, controller state IDLE.

Controller FSM:
- States: IDLE and DECIDE. event_ready = reset_l && state==IDLE.
- Acceptance happens on a rising edge with event_valid && event_ready. At that edge the event is latched and the FSM moves IDLE->DECIDE.
- At the next edge the voice registers update, the chosen pulse bits are registered high, and the FSM returns to IDLE.
- Pulses are high for exactly one cycle: the cycle after DECIDE.
- Throughput: one event per 2 cycles. The producer must hold its fields while valid && !ready.

Per-voice state (FREE / HELD / RELEASING), note-on with velocity > 0:
- If any HELD voice already has the same note, retrigger the lowest-index such voice: pulse voice_note_on, update velocity, age := 0.
- Else take the lowest-index FREE voice.
- Else take the oldest RELEASING voice.
- Else steal the oldest HELD voice.
- "Oldest" means largest age; ties go to the lowest index.
- The target voice becomes HELD with latched note/velocity, age := 0, and voice_note_on[i] pulses.

Note-off, or note-on with velocity 0:
- Every HELD voice with a matching note becomes RELEASING, and its voice_note_off bit pulses.
- If no voice matches, the event is accepted and dropped with no pulse.

Ages:
- On every DECIDE edge, all non-target, non-FREE voice ages increment, saturating at 2^AGE_WIDTH-1.
- FREE voices keep age 0.

envelope_end:
- envelope_end[i] while RELEASING: the voice becomes FREE and voice_active[i] falls the next cycle. Note and velocity are retained; they are don't-care while FREE.
- envelope_end[i] while FREE or HELD is ignored.
- If envelope_end[i] arrives on the same edge as a DECIDE targeting voice i, the DECIDE result wins.

Mid-operation and pulse exclusivity:
- Reset asserted during DECIDE discards the latched event.
- voice_note_on and voice_note_off are never both high for the same voice in a cycle.

Decomposition:
- Package VOICE: voice_state_t enum (FREE, HELD, RELEASING), alloc_state_t (IDLE, DECIDE), and defaults for VOICE_COUNT/AGE_WIDTH.
- Sub-module voice_picker: purely combinational.
  - Inputs: the state, note and age vectors plus the latched event.
  - Outputs: target index, target-valid, and the release mask for note-off.
- voice_allocator holds the FSM, the per-voice registers and the pulse registers.

Test Plan:
1. After reset, note-on 60 vel 100 accepted at edge k -> voice_note_on=8'b0000_0001 during cycle k+1..k+2, voice_note[6:0]=60, voice_active[0]=1, event_ready low one cycle.
2. Note-ons 60, 62, 64 back-to-back -> voices 0, 1, 2 in order. Then note-off 62 -> voice_note_off=8'b0000_0010, voice 1 RELEASING, voice_active[1] stays 1.
3. envelope_end[1] pulse -> voice_active[1]=0. Next note-on 70 -> voice 1 reused.
4. Nine note-ons 40..48 with no note-offs -> ninth steals voice 0 (oldest HELD): voice_note_on[0] pulses, voice_note[0]=48.
5. With voice 3 RELEASING and all others HELD, new note-on -> voice 3 chosen over every HELD voice. Note-on vel 0 for a held note -> treated as note-off pulse.
6. Repeat note-on 60 while 60 is HELD on voice 2 -> retrigger voice 2, no new allocation. envelope_end[2] while HELD -> ignored. Reset asserted during DECIDE -> no pulses, all voices FREE.
